// File: rtl/scoring_pkg.sv
// rtl/scoring_pkg.sv - shared scoring command encodings, FSM state type and BCD helpers
package scoring_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam logic [2:0] CTRL_IDLE   = 3'b000;
    localparam logic [2:0] CTRL_PLAY   = 3'b001;
    localparam logic [2:0] CTRL_REPORT = 3'b010;
    localparam logic [2:0] CTRL_HOLD   = 3'b011;

    // State codes double as the controlSig command, so the output is a plain register copy.
    typedef enum logic [2:0] {
        ST_IDLE   = CTRL_IDLE,
        ST_PLAY   = CTRL_PLAY,
        ST_REPORT = CTRL_REPORT,
        ST_HOLD   = CTRL_HOLD
    } state_t;

    function automatic bcd_digit_t bcd_tens(input int v);
        return bcd_digit_t'((v / 10) % 10);
    endfunction

    function automatic bcd_digit_t bcd_ones(input int v);
        return bcd_digit_t'(v % 10);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD up/down counter with clear, load and saturation at 00/99
module bcd2_counter
    import scoring_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       load_i,
    input  bcd_digit_t load_tens_i,
    input  bcd_digit_t load_ones_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o
);

    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;

    logic at_max;
    logic at_min;

    assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);
    assign at_min = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Simultaneous inc and dec cancel out.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (load_i) begin
            tens_d = load_tens_i;
            ones_d = load_ones_i;
        end else if (inc_i && !dec_i && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec_i && !inc_i && !at_min) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/game_score_counter.sv
// rtl/game_score_counter.sv - round FSM driving a BCD score counter and a BCD countdown timer
module game_score_counter
    import scoring_pkg::*;
#(
    parameter int ROUND_SECS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    input  logic               tick,
    input  logic               abort,
    input  logic               scoreAck,
    output logic [2:0]         controlSig,
    output logic [DIGIT_W-1:0] scoreOnes,
    output logic [DIGIT_W-1:0] scoreTens,
    output logic [DIGIT_W-1:0] timeOnes,
    output logic [DIGIT_W-1:0] timeTens
);

    localparam bcd_digit_t ROUND_TENS = bcd_tens(ROUND_SECS);
    localparam bcd_digit_t ROUND_ONES = bcd_ones(ROUND_SECS);

    state_t state_q, state_d;

    logic sc_clr, sc_inc, sc_dec;
    logic tm_clr, tm_load, tm_dec;
    logic timer_is_one;

    assign timer_is_one = (timeTens == 4'd0) && (timeOnes == 4'd1);

    // Abort wins over everything else in PLAY; the final tick still lets a same-cycle hit/miss land.
    always_comb begin
        state_d = state_q;
        sc_clr  = 1'b0;
        sc_inc  = 1'b0;
        sc_dec  = 1'b0;
        tm_clr  = 1'b0;
        tm_load = 1'b0;
        tm_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sc_clr  = 1'b1;
                    tm_load = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    sc_clr  = 1'b1;
                    tm_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sc_inc = hit;
                    sc_dec = miss;
                    tm_dec = tick;
                    if (tick && timer_is_one) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (scoreAck) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign controlSig = state_q;

    bcd2_counter u_score (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (sc_clr),
        .load_i      (1'b0),
        .load_tens_i (4'd0),
        .load_ones_i (4'd0),
        .inc_i       (sc_inc),
        .dec_i       (sc_dec),
        .tens_o      (scoreTens),
        .ones_o      (scoreOnes)
    );

    bcd2_counter u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (tm_clr),
        .load_i      (tm_load),
        .load_tens_i (ROUND_TENS),
        .load_ones_i (ROUND_ONES),
        .inc_i       (1'b0),
        .dec_i       (tm_dec),
        .tens_o      (timeTens),
        .ones_o      (timeOnes)
    );

endmodule

// File: tb/tb_game_score_counter.sv
// tb/tb_game_score_counter.sv - self-checking bench: 30 s and 3 s rounds against an arithmetic model
module tb_game_score_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, hit = 1'b0, miss = 1'b0, tick = 1'b0, abort = 1'b0, ack = 1'b0;

    logic [2:0] a_ctrl, b_ctrl;
    logic [3:0] a_so, a_st, a_to, a_tt;
    logic [3:0] b_so, b_st, b_to, b_tt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int ctrl;
        int score;
        int timer;
    } mdl_t;

    mdl_t ma = '{0, 0, 0};
    mdl_t mb = '{0, 0, 0};

    always #5 clk = ~clk;

    game_score_counter #(.ROUND_SECS(30)) dut_a (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss), .tick(tick),
        .abort(abort), .scoreAck(ack), .controlSig(a_ctrl),
        .scoreOnes(a_so), .scoreTens(a_st), .timeOnes(a_to), .timeTens(a_tt)
    );

    game_score_counter #(.ROUND_SECS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss), .tick(tick),
        .abort(abort), .scoreAck(ack), .controlSig(b_ctrl),
        .scoreOnes(b_so), .scoreTens(b_st), .timeOnes(b_to), .timeTens(b_tt)
    );

    function automatic mdl_t step(mdl_t m, int secs);
        mdl_t n = m;
        case (m.ctrl)
            0: if (start) begin n.score = 0; n.timer = secs; n.ctrl = 1; end
            1: begin
                if (abort) begin
                    n.score = 0; n.timer = 0; n.ctrl = 0;
                end else begin
                    if (hit && !miss)      n.score = (m.score == 99) ? 99 : m.score + 1;
                    else if (miss && !hit) n.score = (m.score == 0) ? 0 : m.score - 1;
                    if (tick) begin
                        n.timer = (m.timer == 0) ? 0 : m.timer - 1;
                        if (m.timer == 1) n.ctrl = 2;
                    end
                end
            end
            2: n.ctrl = 3;
            default: if (ack) n.ctrl = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{0, 0, 0};
            mb <= '{0, 0, 0};
        end else begin
            ma <= step(ma, 30);
            mb <= step(mb, 3);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_dut(input string tag, input logic [2:0] ctrl, input logic [3:0] st,
                           input logic [3:0] so, input logic [3:0] tt, input logic [3:0] to,
                           input mdl_t m);
        chk({tag, " controlSig"}, int'(ctrl), m.ctrl);
        chk({tag, " score"}, int'(st) * 10 + int'(so), m.score);
        chk({tag, " time"}, int'(tt) * 10 + int'(to), m.timer);
        chk({tag, " scoreOnes bcd"}, int'(so), m.score % 10);
        chk({tag, " timeOnes bcd"}, int'(to), m.timer % 10);
    endtask

    always @(negedge clk) begin
        chk_dut("model A", a_ctrl, a_st, a_so, a_tt, a_to, ma);
        chk_dut("model B", b_ctrl, b_st, b_so, b_tt, b_to, mb);
    end

    task automatic cyc(input logic s, input logic h, input logic ms, input logic tk,
                       input logic ab, input logic ak);
        start = s; hit = h; miss = ms; tick = tk; abort = ab; ack = ak;
        @(negedge clk);
        start = 0; hit = 0; miss = 0; tick = 0; abort = 0; ack = 0;
    endtask

    task automatic lit(input string name, input logic [2:0] ctrl, input logic [3:0] st,
                       input logic [3:0] so, input logic [3:0] tt, input logic [3:0] to,
                       input int e_ctrl, input int e_score, input int e_time);
        chk({name, " ctrl"}, int'(ctrl), e_ctrl);
        chk({name, " score"}, int'(st) * 10 + int'(so), e_score);
        chk({name, " time"}, int'(tt) * 10 + int'(to), e_time);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("reset A", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        lit("idle after reset", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);

        cyc(1, 0, 0, 0, 0, 0);
        lit("start A", a_ctrl, a_st, a_so, a_tt, a_to, 1, 0, 30);
        lit("start B", b_ctrl, b_st, b_so, b_tt, b_to, 1, 0, 3);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0);
        lit("12 hits", a_ctrl, a_st, a_so, a_tt, a_to, 1, 12, 30);

        for (int i = 0; i < 93; i++) cyc(0, 1, 0, 0, 0, 0);
        lit("105 hits saturate", a_ctrl, a_st, a_so, a_tt, a_to, 1, 99, 30);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        lit("3 misses", a_ctrl, a_st, a_so, a_tt, a_to, 1, 96, 30);

        cyc(0, 0, 0, 0, 1, 0);
        lit("abort clears", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        lit("miss at floor", a_ctrl, a_st, a_so, a_tt, a_to, 1, 0, 30);
        cyc(0, 1, 1, 0, 0, 0);
        lit("hit+miss at floor", a_ctrl, a_st, a_so, a_tt, a_to, 1, 0, 30);

        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        lit("5 hits 1 tick A", a_ctrl, a_st, a_so, a_tt, a_to, 1, 5, 29);
        lit("5 hits 1 tick B", b_ctrl, b_st, b_so, b_tt, b_to, 1, 5, 2);
        cyc(0, 1, 0, 1, 1, 0);
        lit("abort priority", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        lit("fresh round", a_ctrl, a_st, a_so, a_tt, a_to, 1, 0, 30);

        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        lit("last tick B", b_ctrl, b_st, b_so, b_tt, b_to, 2, 1, 0);
        lit("last tick A", a_ctrl, a_st, a_so, a_tt, a_to, 1, 1, 27);
        cyc(0, 0, 0, 0, 0, 1);
        lit("ack in report ignored", b_ctrl, b_st, b_so, b_tt, b_to, 3, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        lit("start in hold", b_ctrl, b_st, b_so, b_tt, b_to, 3, 1, 0);
        cyc(0, 1, 0, 1, 1, 0);
        lit("hit in hold", b_ctrl, b_st, b_so, b_tt, b_to, 3, 1, 0);
        lit("abort priority A", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        lit("ack to idle B", b_ctrl, b_st, b_so, b_tt, b_to, 0, 1, 0);
        lit("A replay", a_ctrl, a_st, a_so, a_tt, a_to, 1, 1, 30);
        cyc(0, 0, 0, 1, 0, 0);
        lit("idle keeps score B", b_ctrl, b_st, b_so, b_tt, b_to, 0, 1, 0);

        #2 rst = 1'b1;
        #1;
        lit("async reset A", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        lit("async reset B", b_ctrl, b_st, b_so, b_tt, b_to, 0, 0, 0);
        @(negedge clk);
        cyc(1, 1, 0, 1, 0, 0);
        lit("hit under reset", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        lit("after release", a_ctrl, a_st, a_so, a_tt, a_to, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_score_counter.md
GAME_SCORE_COUNTER -- requirements
Module: game_score_counter

Interface
REQ-001 The block SHALL have one parameter: ROUND_SECS, default 30, round length in seconds (legal range 1..99).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  one-cycle pulse that begins a round.
REQ-005 The block SHALL have port hit  input  1  one-cycle pulse that adds one point.
REQ-006 The block SHALL have port miss  input  1  one-cycle pulse that removes one point.
REQ-007 The block SHALL have port tick  input  1  one-cycle 1 Hz enable from the prescaler.
REQ-008 The block SHALL have port abort  input  1  cancels a running round.
REQ-009 The block SHALL have port scoreAck  input  1  the Scoring block has consumed the final score.
REQ-010 The block SHALL have port controlSig  output  3  command to the Scoring block: 000 idle, 001 playing, 010 score valid, 011 awaiting ack.
REQ-011 The block SHALL have port scoreOnes  output  4  BCD score units digit.
REQ-012 The block SHALL have port scoreTens  output  4  BCD score tens digit.
REQ-013 The block SHALL have port timeOnes  output  4  BCD seconds-remaining units digit.
REQ-014 The block SHALL have port timeTens  output  4  BCD seconds-remaining tens digit.

Function
REQ-015 The FSM SHALL have the states IDLE, PLAY, REPORT and HOLD; controlSig SHALL be 000, 001, 010 and 011 respectively, driven from registered state.
REQ-016 In IDLE, start SHALL clear the score to 00, load the timer with ROUND_SECS in BCD, and enter PLAY on the same edge.
REQ-017 In PLAY, hit alone SHALL increment the score by one BCD step (ones 9->0 with carry into tens) and SHALL saturate at 99.
REQ-018 In PLAY, miss alone SHALL decrement the score by one BCD step (ones 0->9 with borrow) and SHALL floor at 00.
REQ-019 In PLAY, hit and miss asserted in the same cycle SHALL leave the score unchanged.
REQ-020 In PLAY, tick SHALL decrement the BCD timer by one.
REQ-021 A tick with the timer at 01 SHALL set the timer to 00 and enter REPORT; a hit or miss in that same cycle SHALL still be applied.
REQ-022 Score and timer updates SHALL take effect on the sampling edge and be visible in the following cycle (1-cycle latency).
REQ-023 REPORT SHALL last exactly one cycle and then go to HOLD.
REQ-024 HOLD SHALL hold the score stable until scoreAck is asserted, then go to IDLE; a scoreAck arriving in REPORT SHALL be ignored.
REQ-025 In PLAY, abort SHALL clear the score and timer to 00 and go to IDLE with no REPORT; abort SHALL take priority over tick, hit and miss.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 hit, miss and tick SHALL be ignored outside PLAY.
REQ-028 abort SHALL be ignored outside PLAY.
REQ-029 In IDLE, the score outputs SHALL keep the last round's result until the next start.

Reset
REQ-030 On assertion of rst, the block SHALL immediately enter IDLE, including mid-round, with no report issued.
REQ-031 While rst is asserted, controlSig SHALL be 000 and scoreOnes, scoreTens, timeOnes and timeTens SHALL all be 0.
REQ-032 Release of rst SHALL take effect at the next rising edge of clk.

Structure
REQ-033 The controlSig encodings, the FSM state type and the BCD digit width SHALL live in the shared package scoring_pkg, which the Scoring block also uses.
REQ-034 A single sub-module, bcd2_counter (two-digit BCD up/down counter with load, clear and saturate-at-bounds), SHALL be instantiated twice: once for the score and once for the timer.
REQ-035 Only bcd2_counter and the FSM SHALL hold state.

Verification
REQ-036 Reset, then start, then 12 hits -> score 12 one cycle after the last hit; controlSig 001; timer 30.
REQ-037 In PLAY, 105 hits, then 3 misses -> score 99 after the hits, then 96.
REQ-038 With score 00, a miss, then hit and miss in the same cycle -> score stays 00 throughout.
REQ-039 ROUND_SECS=3: start, 3 ticks with a hit on the third tick -> timer 00, score 01, controlSig 010 for exactly one cycle, then 011 until scoreAck, then 000.
REQ-040 Abort after 5 hits and 1 tick -> next cycle controlSig 000 and score/timer 00; a following start begins a fresh round (timer 30).
REQ-041 Assert rst asynchronously between clock edges during PLAY -> outputs go to their reset values before the next edge; hit while rst is held -> no change.
